// File: rtl/mux_dff_arbiter_if.sv
// Handshake bundle for the shared mux-plus-register stage: two requesters in, one result out.
// Latency: none (wires only); the registered stage lives in mux_dff_arbiter.
// Backpressure: out_ready from downstream gates in0_ready/in1_ready back to the requesters.
// Ports: in0_valid/in0_data/in0_ready, in1_valid/in1_data/in1_ready,
//        out_valid/out_data/out_sel/out_ready.
// master = requester/downstream side, slave = arbiter side.
interface mux_dff_arbiter_if #(
  parameter int DATA_W = 24
);
  logic              in0_valid;
  logic [DATA_W-1:0] in0_data;
  logic              in0_ready;
  logic              in1_valid;
  logic [DATA_W-1:0] in1_data;
  logic              in1_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_sel;
  logic              out_ready;

  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux_dff_arbiter.sv
// Round-robin (with burst allowance) 2:1 arbiter feeding one registered select stage.
// Latency: 1 cycle from inX_valid&inX_ready to out_valid/out_data/out_sel.
// Backpressure: pass-through ready; readys drop only while the output is full and out_ready is low.
// Ports: clk, rst (async, active-high), bus (mux_dff_arbiter_if.slave).
// Optional MUX_DFF_ARB_STAT_EN adds stat_clr input and 16-bit grant_cnt0/grant_cnt1 outputs.
module mux_dff_arbiter #(
  parameter int DATA_W = 24,
  parameter int BURST  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  mux_dff_arbiter_if.slave    bus
`ifdef MUX_DFF_ARB_STAT_EN
  ,
  input  logic                stat_clr,
  output logic [15:0]         grant_cnt0,
  output logic [15:0]         grant_cnt1
`endif
);

  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q;
  logic [CNT_W-1:0]  burst_cnt_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_sel_q;

  logic              out_valid;
  logic              space;
  logic              any_valid;
  logic              load;
  logic              grant;

  assign out_valid = (state_q == FULL);
  // Pass-through ready: a full register that drains this edge can reload the same edge.
  assign space     = !out_valid || bus.out_ready;
  assign any_valid = bus.in0_valid || bus.in1_valid;
  // Readys are held low while rst is high even though the register already reads as empty.
  assign load      = space && any_valid && !rst;

  // Grant: a lone requester always wins; when contested, the last winner keeps
  // the path until it has used up its burst allowance.
  always_comb begin
    grant = last_grant_q;
    if (bus.in0_valid && !bus.in1_valid) begin
      grant = 1'b0;
    end else if (!bus.in0_valid && bus.in1_valid) begin
      grant = 1'b1;
    end else if (bus.in0_valid && bus.in1_valid) begin
      grant = (burst_cnt_q < BURST_C) ? last_grant_q : ~last_grant_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.in0_ready = 1'b0;
    bus.in1_ready = 1'b0;
    case (state_q)
      EMPTY: begin
        if (load) state_d = FULL;
      end
      FULL: begin
        if (load) begin
          state_d = FULL;
        end else if (bus.out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (load) begin
      bus.in0_ready = !grant;
      bus.in1_ready = grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q   <= '0;
      out_sel_q    <= 1'b0;
      last_grant_q <= 1'b1;
      burst_cnt_q  <= BURST_C;
    end else if (load) begin
      out_data_q   <= grant ? bus.in1_data : bus.in0_data;
      out_sel_q    <= grant;
      last_grant_q <= grant;
      if (grant == last_grant_q) begin
        burst_cnt_q <= (burst_cnt_q >= BURST_C) ? BURST_C : burst_cnt_q + ONE_C;
      end else begin
        burst_cnt_q <= ONE_C;
      end
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

`ifdef MUX_DFF_ARB_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (stat_clr) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (bus.in0_ready && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (bus.in1_ready && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_dff_arbiter.sv
// Directed bench for mux_dff_arbiter: BURST=2 main instance plus a BURST=1 instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1-2 units after it.
module tb_mux_dff_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mux_dff_arbiter_if #(.DATA_W(24)) bus  ();
  mux_dff_arbiter_if #(.DATA_W(24)) bus1 ();

`ifdef MUX_DFF_ARB_STAT_EN
  logic        stat_clr = 1'b0;
  logic [15:0] grant_cnt0, grant_cnt1;
  logic        stat_clr1 = 1'b0;
  logic [15:0] grant_cnt0_b1, grant_cnt1_b1;
`endif

  mux_dff_arbiter #(.DATA_W(24), .BURST(2), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef MUX_DFF_ARB_STAT_EN
    ,
    .stat_clr   (stat_clr),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  mux_dff_arbiter #(.DATA_W(24), .BURST(1), .CNT_W(8)) dut_b1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
`ifdef MUX_DFF_ARB_STAT_EN
    ,
    .stat_clr   (stat_clr1),
    .grant_cnt0 (grant_cnt0_b1),
    .grant_cnt1 (grant_cnt1_b1)
`endif
  );

  task automatic idle_inputs();
    bus.in0_valid  = 1'b0; bus.in0_data = '0;
    bus.in1_valid  = 1'b0; bus.in1_data = '0;
    bus.out_ready  = 1'b1;
    bus1.in0_valid = 1'b0; bus1.in0_data = '0;
    bus1.in1_valid = 1'b0; bus1.in1_data = '0;
    bus1.out_ready = 1'b1;
  endtask

  // Reset pulse, released 1 unit after a rising edge.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== 24'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 000000", bus.out_data); end
    n_checks++;
    if (bus.out_sel !== 1'b0) begin n_fail++; $display("FAIL reset_out_sel got %0b want 0", bus.out_sel); end
    n_checks++;
    if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_readys got %b want 00", {bus.in0_ready, bus.in1_ready}); end
  endtask

  task automatic test_single();
    do_reset();
    bus.in0_valid = 1'b1; bus.in0_data = 24'h000011; bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if ({bus.in0_ready, bus.in1_ready} !== 2'b10) begin n_fail++; $display("FAIL single_ready got %b want 10", {bus.in0_ready, bus.in1_ready}); end
    tick();
    bus.in0_valid = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 1'b0, 24'h000011}) begin
      n_fail++; $display("FAIL single_out got v=%0b s=%0b d=%h want v=1 s=0 d=000011", bus.out_valid, bus.out_sel, bus.out_data);
    end
    tick();
    // Drain with no new load: valid drops, data and sel hold.
    n_checks++;
    if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b0, 1'b0, 24'h000011}) begin
      n_fail++; $display("FAIL single_drain got v=%0b s=%0b d=%h want v=0 s=0 d=000011", bus.out_valid, bus.out_sel, bus.out_data);
    end
  endtask

  task automatic test_round_robin();
    logic exp_g [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [23:0] exp_d;
    do_reset();
    bus.in0_valid = 1'b1; bus.in0_data = 24'h00000A;
    bus.in1_valid = 1'b1; bus.in1_data = 24'h00000B;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if ({bus.in0_ready, bus.in1_ready} !== {~exp_g[i], exp_g[i]}) begin
        n_fail++; $display("FAIL rr_grant[%0d] got %b want %b", i, {bus.in0_ready, bus.in1_ready}, {~exp_g[i], exp_g[i]});
      end
      tick();
      exp_d = exp_g[i] ? 24'h00000B : 24'h00000A;
      n_checks++;
      if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, exp_g[i], exp_d}) begin
        n_fail++; $display("FAIL rr_out[%0d] got v=%0b s=%0b d=%h want v=1 s=%0b d=%h", i, bus.out_valid, bus.out_sel, bus.out_data, exp_g[i], exp_d);
      end
    end
    idle_inputs();
  endtask

  task automatic test_burst1();
    logic exp_g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    bus1.in0_valid = 1'b1; bus1.in0_data = 24'h000A0A;
    bus1.in1_valid = 1'b1; bus1.in1_data = 24'h000B0B;
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if ({bus1.in0_ready, bus1.in1_ready} !== {~exp_g[i], exp_g[i]}) begin
        n_fail++; $display("FAIL b1_grant[%0d] got %b want %b", i, {bus1.in0_ready, bus1.in1_ready}, {~exp_g[i], exp_g[i]});
      end
      tick();
      n_checks++;
      if (bus1.out_sel !== exp_g[i]) begin
        n_fail++; $display("FAIL b1_out_sel[%0d] got %0b want %0b", i, bus1.out_sel, exp_g[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.in1_valid = 1'b1; bus.in1_data = 24'h000055; bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in0_valid = 1'b1; bus.in0_data = 24'h00000A;
    bus.in1_data  = 24'h00000B;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin
        n_fail++; $display("FAIL bp_readys[%0d] got %b want 00", i, {bus.in0_ready, bus.in1_ready});
      end
      tick();
      n_checks++;
      if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 1'b1, 24'h000055}) begin
        n_fail++; $display("FAIL bp_hold[%0d] got v=%0b s=%0b d=%h want v=1 s=1 d=000055", i, bus.out_valid, bus.out_sel, bus.out_data);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if ({bus.in0_ready, bus.in1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL bp_release_ready got %b want 10", {bus.in0_ready, bus.in1_ready});
    end
    tick();
    n_checks++;
    if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 1'b0, 24'h00000A}) begin
      n_fail++; $display("FAIL bp_handoff got v=%0b s=%0b d=%h want v=1 s=0 d=00000a", bus.out_valid, bus.out_sel, bus.out_data);
    end
    idle_inputs();
  endtask

  task automatic test_burst_saturation();
    do_reset();
    bus.in1_valid = 1'b1; bus.in1_data = 24'h000111; bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if ({bus.in0_ready, bus.in1_ready} !== 2'b01) begin
        n_fail++; $display("FAIL sat_solo[%0d] got %b want 01", i, {bus.in0_ready, bus.in1_ready});
      end
      tick();
    end
    bus.in0_valid = 1'b1; bus.in0_data = 24'h000222;
    #1;
    n_checks++;
    if ({bus.in0_ready, bus.in1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL sat_contested got %b want 10", {bus.in0_ready, bus.in1_ready});
    end
    tick();
    n_checks++;
    if ({bus.out_sel, bus.out_data} !== {1'b0, 24'h000222}) begin
      n_fail++; $display("FAIL sat_out got s=%0b d=%h want s=0 d=000222", bus.out_sel, bus.out_data);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.in0_valid = 1'b1; bus.in0_data = 24'h0000C3;
    bus.in1_valid = 1'b1; bus.in1_data = 24'h00003C;
    bus.out_ready = 1'b0;
    tick();
    n_checks++;
    if ({bus.out_valid, bus.out_data} !== {1'b1, 24'h0000C3}) begin
      n_fail++; $display("FAIL rmid_loaded got v=%0b d=%h want v=1 d=0000c3", bus.out_valid, bus.out_data);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.out_data, bus.out_sel} !== {1'b0, 24'h0, 1'b0}) begin
      n_fail++; $display("FAIL rmid_async got v=%0b d=%h s=%0b want v=0 d=000000 s=0", bus.out_valid, bus.out_data, bus.out_sel);
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if ({bus.in0_ready, bus.in1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL rmid_readys got %b want 00", {bus.in0_ready, bus.in1_ready});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
  endtask

`ifdef MUX_DFF_ARB_STAT_EN
  task automatic test_stats();
    do_reset();
    stat_clr = 1'b0;
    bus.in0_valid = 1'b1; bus.in0_data = 24'h000044; bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.in0_valid = 1'b0;
    tick();
    n_checks++;
    if ({grant_cnt0, grant_cnt1} !== {16'd4, 16'd0}) begin
      n_fail++; $display("FAIL stat_count got %0d/%0d want 4/0", grant_cnt0, grant_cnt1);
    end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    n_checks++;
    if ({grant_cnt0, grant_cnt1} !== {16'd0, 16'd0}) begin
      n_fail++; $display("FAIL stat_clr got %0d/%0d want 0/0", grant_cnt0, grant_cnt1);
    end
    idle_inputs();
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_burst1();
    test_backpressure();
    test_burst_saturation();
    test_reset_mid();
`ifdef MUX_DFF_ARB_STAT_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
